// File: rtl/instruction_fetcher_if.sv
// Fetch-stage bus: instruction-cache read port, redirect input and decoder queue head.
// Naming is seen from the fetcher: master = fetcher, slave = cache/ROB/decoder side.
interface instruction_fetcher_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int INST_WIDTH = 32
);
    logic                  rdy;
    logic [ADDR_WIDTH-1:0] cache_read_addr;
    logic                  cache_read_done;
    logic [INST_WIDTH-1:0] cache_read_data;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] flush_pc;
    logic                  dec_valid;
    logic [INST_WIDTH-1:0] dec_inst;
    logic [ADDR_WIDTH-1:0] dec_pc;
    logic                  dec_pred_taken;
    logic                  dec_pop;

    modport master (
        input  rdy,
        output cache_read_addr,
        input  cache_read_done,
        input  cache_read_data,
        input  flush,
        input  flush_pc,
        output dec_valid,
        output dec_inst,
        output dec_pc,
        output dec_pred_taken,
        input  dec_pop
    );

    modport slave (
        output rdy,
        input  cache_read_addr,
        output cache_read_done,
        output cache_read_data,
        output flush,
        output flush_pc,
        input  dec_valid,
        input  dec_inst,
        input  dec_pc,
        input  dec_pred_taken,
        output dec_pop
    );
endinterface

// File: rtl/instruction_fetcher.sv
// Fetch stage: PC register, instruction queue toward the decoder, flush redirect.
// Optional fetch-time JAL target prediction is enabled with `define FETCH_JAL_PREDICT_EN.
module instruction_fetcher #(
    parameter int ADDR_WIDTH      = 17,
    parameter int INST_WIDTH      = 32,
    parameter int QUEUE_DEPTH_LOG = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    instruction_fetcher_if.master  bus
);
    localparam int DEPTH = 1 << QUEUE_DEPTH_LOG;
    localparam logic [QUEUE_DEPTH_LOG:0]   FULL_COUNT = (QUEUE_DEPTH_LOG+1)'(DEPTH);
    localparam logic [QUEUE_DEPTH_LOG:0]   CNT_ONE    = (QUEUE_DEPTH_LOG+1)'(1);
    localparam logic [QUEUE_DEPTH_LOG-1:0] PTR_ONE    = QUEUE_DEPTH_LOG'(1);

    logic [ADDR_WIDTH-1:0]      r_pc;
    logic [QUEUE_DEPTH_LOG-1:0] r_head;
    logic [QUEUE_DEPTH_LOG-1:0] r_tail;
    logic [QUEUE_DEPTH_LOG:0]   r_count;
    logic [INST_WIDTH-1:0]      r_inst_q [DEPTH];
    logic [ADDR_WIDTH-1:0]      r_pc_q   [DEPTH];

    logic                       w_full;
    logic                       w_empty;
    logic                       w_push;
    logic                       w_pop;
    logic [ADDR_WIDTH-1:0]      w_next_pc;

    // Handshake: the cache hit (cache_read_done) is the valid for cache_read_addr and is
    // accepted when the queue has room; dec_valid/dec_pop form a valid/ready pair where a
    // pop is taken only while dec_valid=1. Everything is qualified by rdy, and flush wins.
    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.cache_read_done && !w_full && !bus.flush;
    assign w_pop   = bus.dec_pop && !w_empty && !bus.flush;

`ifdef FETCH_JAL_PREDICT_EN
    logic                       r_pred_q [DEPTH];
    logic                       w_is_jal;
    logic signed [20:0]         w_jal_imm;

    assign w_is_jal  = (bus.cache_read_data[6:0] == 7'b1101111);
    // J-type immediate: imm[20|10:1|11|19:12] packed in inst[31:12].
    assign w_jal_imm = {bus.cache_read_data[31], bus.cache_read_data[19:12],
                        bus.cache_read_data[20], bus.cache_read_data[30:21], 1'b0};
    assign w_next_pc = w_is_jal ? (r_pc + ADDR_WIDTH'(w_jal_imm))
                                : (r_pc + ADDR_WIDTH'(4));
    assign bus.dec_pred_taken = r_pred_q[r_head];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pred_q[i] <= 1'b0;
            end
        end else if (bus.rdy && w_push) begin
            r_pred_q[r_tail] <= w_is_jal;
        end
    end
`else
    assign w_next_pc          = r_pc + ADDR_WIDTH'(4);
    assign bus.dec_pred_taken = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc    <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_inst_q[i] <= '0;
                r_pc_q[i]   <= '0;
            end
        end else if (bus.rdy) begin
            if (bus.flush) begin
                r_pc    <= bus.flush_pc;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_inst_q[r_tail] <= bus.cache_read_data;
                    r_pc_q[r_tail]   <= r_pc;
                    r_tail           <= r_tail + PTR_ONE;
                    r_pc             <= w_next_pc;
                end
                if (w_pop) begin
                    r_head <= r_head + PTR_ONE;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_ONE;
                    2'b01:   r_count <= r_count - CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign bus.cache_read_addr = r_pc;
    assign bus.dec_valid       = !w_empty;
    assign bus.dec_inst        = r_inst_q[r_head];
    assign bus.dec_pc          = r_pc_q[r_head];

endmodule
